panda_divseq: RTL and testbench

Sequencer that schedules a `panda_div` pulse divider through a programmable table of up to four divisor settings. It counts divided pulses per setting and reloads the next setting with a one-cycle divider reset between steps. It sits between the register bank and a `panda_div` instance: it drives that divider's `DIVISOR` and `rst_i` and monitors its `outd_o`.

---
 rtl/panda_divseq.sv | 201 ++++++++++++++++++++
 tb/tb_panda_divseq.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/panda_divseq.sv
// panda_divseq: steps a panda_div pulse divider through up to four divisor/repeat entries.
// Optional macro PANDA_DIVSEQ_PASS_COUNT_EN: repeat the table CYCLES times (0 = forever).
module panda_divseq #(
    parameter int NUM_ENTRIES = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic        outd_i,
    input  logic [31:0] DIV0,
    input  logic [31:0] DIV1,
    input  logic [31:0] DIV2,
    input  logic [31:0] DIV3,
    input  logic [31:0] REP0,
    input  logic [31:0] REP1,
    input  logic [31:0] REP2,
    input  logic [31:0] REP3,
    input  logic [2:0]  TABLE_LEN,
    input  logic [31:0] CYCLES,
    output logic [31:0] divisor_o,
    output logic        div_rst_o,
    output logic        active_o,
    output logic        done_o,
    output logic [1:0]  ENTRY,
    output logic [31:0] PASS_COUNT,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [2:0] MAX_LEN = 3'(NUM_ENTRIES);

    state_t      state_q, state_d;
    logic        enable_q;
    logic        outd_q;
    logic [31:0] pulse_cnt_q, pulse_cnt_d;
    logic [31:0] target_q, target_d;
    logic [31:0] pass_cnt_q, pass_cnt_d;
    logic [1:0]  entry_q, entry_d;
    logic [31:0] divisor_q, divisor_d;
    logic        div_rst_q, div_rst_d;
    logic        active_q, active_d;
    logic        done_q, done_d;

    logic        enable_rise;
    logic        outd_rise;
    logic [2:0]  tlen_eff;
    logic [1:0]  last_entry;
    logic [31:0] pulse_next;
    logic [31:0] pass_next;
    logic        continue_pass;
    logic [31:0] div_sel;
    logic [31:0] rep_sel;

    assign enable_rise = enable_i & ~enable_q;
    assign outd_rise   = outd_i & ~outd_q;
    assign pulse_next  = pulse_cnt_q + 32'd1;
    assign pass_next   = pass_cnt_q + 32'd1;

    // TABLE_LEN is read live, so a shrinking table ends the pass at the next entry end.
    always_comb begin
        tlen_eff = TABLE_LEN;
        if (TABLE_LEN == 3'd0) begin
            tlen_eff = 3'd1;
        end else if (TABLE_LEN > MAX_LEN) begin
            tlen_eff = MAX_LEN;
        end
    end

    assign last_entry = 2'(tlen_eff - 3'd1);

`ifdef PANDA_DIVSEQ_PASS_COUNT_EN
    assign continue_pass = (CYCLES == 32'd0) || (pass_next < CYCLES);
`else
    logic unused_cycles;
    assign unused_cycles = ^CYCLES;
    assign continue_pass = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            enable_q    <= 1'b0;
            outd_q      <= 1'b0;
            pulse_cnt_q <= 32'd0;
            target_q    <= 32'd1;
            pass_cnt_q  <= 32'd0;
            entry_q     <= 2'd0;
            divisor_q   <= 32'd0;
            div_rst_q   <= 1'b1;
            active_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            enable_q    <= enable_i;
            outd_q      <= outd_i;
            pulse_cnt_q <= pulse_cnt_d;
            target_q    <= target_d;
            pass_cnt_q  <= pass_cnt_d;
            entry_q     <= entry_d;
            divisor_q   <= divisor_d;
            div_rst_q   <= div_rst_d;
            active_q    <= active_d;
            done_q      <= done_d;
        end
    end

    // Abort (enable low) outranks a terminating pulse arriving in the same cycle.
    always_comb begin
        state_d     = state_q;
        entry_d     = entry_q;
        pass_cnt_d  = pass_cnt_q;
        pulse_cnt_d = pulse_cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (enable_rise) begin
                    state_d     = S_LOAD;
                    entry_d     = 2'd0;
                    pass_cnt_d  = 32'd0;
                    pulse_cnt_d = 32'd0;
                end
            end
            S_LOAD: begin
                pulse_cnt_d = 32'd0;
                state_d     = enable_i ? S_RUN : S_IDLE;
            end
            S_RUN: begin
                if (!enable_i) begin
                    state_d = S_IDLE;
                end else if (outd_rise) begin
                    pulse_cnt_d = pulse_next;
                    if (pulse_next == target_q) begin
                        if (entry_q < last_entry) begin
                            entry_d = entry_q + 2'd1;
                            state_d = S_LOAD;
                        end else begin
                            pass_cnt_d = pass_next;
                            if (continue_pass) begin
                                entry_d = 2'd0;
                                state_d = S_LOAD;
                            end else begin
                                state_d = S_DONE;
                            end
                        end
                    end
                end
            end
            S_DONE: begin
                if (!enable_i) begin
                    state_d = S_IDLE;
                end else if (enable_rise) begin
                    state_d     = S_LOAD;
                    entry_d     = 2'd0;
                    pass_cnt_d  = 32'd0;
                    pulse_cnt_d = 32'd0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        div_sel = DIV0;
        rep_sel = REP0;
        case (entry_d)
            2'd0: begin div_sel = DIV0; rep_sel = REP0; end
            2'd1: begin div_sel = DIV1; rep_sel = REP1; end
            2'd2: begin div_sel = DIV2; rep_sel = REP2; end
            2'd3: begin div_sel = DIV3; rep_sel = REP3; end
            default: begin div_sel = DIV0; rep_sel = REP0; end
        endcase
    end

    // The table is sampled on entry to LOAD so the new divisor is already
    // on divisor_o during the single reset cycle the divider sees.
    always_comb begin
        divisor_d = divisor_q;
        target_d  = target_q;
        if (state_d == S_LOAD) begin
            divisor_d = div_sel;
            target_d  = (rep_sel == 32'd0) ? 32'd1 : rep_sel;
        end
        div_rst_d = (state_d != S_RUN);
        active_d  = (state_d == S_RUN);
        done_d    = (state_d == S_DONE);
    end

    assign divisor_o  = divisor_q;
    assign div_rst_o  = div_rst_q;
    assign active_o   = active_q;
    assign done_o     = done_q;
    assign ENTRY      = entry_q;
    assign PASS_COUNT = pass_cnt_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_panda_divseq.sv
// Bench for panda_divseq: table-driven table runs plus hand sequences for reset, abort,
// mid-run table edits and multi-pass operation.
module tb_panda_divseq;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    logic        clk;
    logic        rst_i;
    logic        enable_i;
    logic        outd_i;
    logic [31:0] DIV0, DIV1, DIV2, DIV3;
    logic [31:0] REP0, REP1, REP2, REP3;
    logic [2:0]  TABLE_LEN;
    logic [31:0] CYCLES;
    logic [31:0] divisor_o;
    logic        div_rst_o;
    logic        active_o;
    logic        done_o;
    logic [1:0]  ENTRY;
    logic [31:0] PASS_COUNT;
    logic [1:0]  state_o;

    typedef struct {
        logic [2:0]        tlen;
        logic [3:0][31:0]  div;
        logic [3:0][31:0]  rep;
        int                exp_len;
    } vec_t;

    vec_t        vecs[5];
    logic [33:0] exp_q[$];
    int          checks;
    int          errors;

    panda_divseq dut (
        .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .outd_i(outd_i),
        .DIV0(DIV0), .DIV1(DIV1), .DIV2(DIV2), .DIV3(DIV3),
        .REP0(REP0), .REP1(REP1), .REP2(REP2), .REP3(REP3),
        .TABLE_LEN(TABLE_LEN), .CYCLES(CYCLES),
        .divisor_o(divisor_o), .div_rst_o(div_rst_o), .active_o(active_o),
        .done_o(done_o), .ENTRY(ENTRY), .PASS_COUNT(PASS_COUNT), .state_o(state_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // scoreboard: every LOAD cycle must match the next expected {entry, divisor}
    task automatic mon();
        logic [33:0] e;
        if (state_o == S_LOAD) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL load_unexpected: got entry %0d div 0x%0h, expected no load", ENTRY, divisor_o);
            end else begin
                e = exp_q.pop_front();
                check("load_entry", 64'(ENTRY), 64'(e[33:32]));
                check("load_divisor", 64'(divisor_o), 64'(e[31:0]));
                check("load_div_rst", 64'(div_rst_o), 64'd1);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        mon();
    endtask

    task automatic pulse();
        outd_i = 1'b1;
        tick();
        outd_i = 1'b0;
        tick();
        tick();
    endtask

    task automatic wait_active();
        int n = 0;
        while (active_o !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("active_reached", 64'(active_o), 64'd1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_o !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("done_reached", 64'(done_o), 64'd1);
    endtask

    task automatic go_idle();
        enable_i = 1'b0;
        outd_i   = 1'b0;
        tick();
        tick();
        check("idle_state", 64'(state_o), 64'(S_IDLE));
    endtask

    task automatic apply(input vec_t v);
        TABLE_LEN = v.tlen;
        DIV0 = v.div[0]; DIV1 = v.div[1]; DIV2 = v.div[2]; DIV3 = v.div[3];
        REP0 = v.rep[0]; REP1 = v.rep[1]; REP2 = v.rep[2]; REP3 = v.rep[3];
    endtask

    initial begin
        int exp_passes;
        checks = 0;
        errors = 0;

        vecs[0] = '{tlen: 3'd2, div: {32'd0, 32'd0, 32'd5, 32'd3}, rep: {32'd0, 32'd0, 32'd1, 32'd2}, exp_len: 2};
        vecs[1] = '{tlen: 3'd0, div: {32'd0, 32'd0, 32'd0, 32'd13}, rep: {32'd5, 32'd5, 32'd5, 32'd0}, exp_len: 1};
        vecs[2] = '{tlen: 3'd4, div: {32'd10, 32'd9, 32'd8, 32'd7}, rep: {32'd3, 32'd1, 32'd2, 32'd1}, exp_len: 4};
        vecs[3] = '{tlen: 3'd7, div: {32'hffffffff, 32'd1, 32'd2, 32'd100}, rep: {32'd1, 32'd1, 32'd1, 32'd0}, exp_len: 4};
        vecs[4] = '{tlen: 3'd3, div: '0, rep: '0, exp_len: 3};
        for (int i = 0; i < 4; i++) begin
            vecs[4].div[i] = $urandom();
            vecs[4].rep[i] = 32'($urandom_range(1, 3));
        end

        rst_i = 1'b1; enable_i = 1'b0; outd_i = 1'b0; CYCLES = 32'd1;
        apply(vecs[0]);
        repeat (3) tick();
        check("rst_state", 64'(state_o), 64'(S_IDLE));
        check("rst_div_rst", 64'(div_rst_o), 64'd1);
        check("rst_divisor", 64'(divisor_o), 64'd0);
        check("rst_entry", 64'(ENTRY), 64'd0);
        check("rst_pass", 64'(PASS_COUNT), 64'd0);
        check("rst_active", 64'(active_o), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);
        rst_i = 1'b0;
        tick();

        // table-driven single-pass runs
        for (int v = 0; v < 5; v++) begin
            apply(vecs[v]);
            for (int e = 0; e < vecs[v].exp_len; e++)
                exp_q.push_back({2'(e), vecs[v].div[e]});
            enable_i = 1'b1;
            for (int e = 0; e < vecs[v].exp_len; e++) begin
                wait_active();
                repeat ((vecs[v].rep[e] == 32'd0) ? 1 : int'(vecs[v].rep[e])) pulse();
            end
            wait_done();
            check("vec_done_active", 64'(active_o), 64'd0);
            check("vec_done_div_rst", 64'(div_rst_o), 64'd1);
            check("vec_done_pass", 64'(PASS_COUNT), 64'd1);
            check("vec_done_entry", 64'(ENTRY), 64'(vecs[v].exp_len - 1));
            check("vec_done_divisor", 64'(divisor_o), 64'(vecs[v].div[vecs[v].exp_len - 1]));
            check("vec_queue_empty", 64'(exp_q.size()), 64'd0);
            go_idle();
            check("vec_idle_done", 64'(done_o), 64'd0);
        end

        // load/run timing, one reset cycle per step, DIV1 edited mid-run
        TABLE_LEN = 3'd2; DIV0 = 32'd11; REP0 = 32'd1; DIV1 = 32'd22; REP1 = 32'd1;
        exp_q.push_back({2'd0, 32'd11});
        enable_i = 1'b1;
        tick();
        check("t1_state", 64'(state_o), 64'(S_LOAD));
        check("t1_div_rst", 64'(div_rst_o), 64'd1);
        tick();
        check("t2_state", 64'(state_o), 64'(S_RUN));
        check("t2_div_rst", 64'(div_rst_o), 64'd0);
        check("t2_divisor", 64'(divisor_o), 64'd11);
        DIV1 = 32'd33;
        exp_q.push_back({2'd1, 32'd33});
        outd_i = 1'b1;
        tick();
        check("step_entry", 64'(ENTRY), 64'd1);
        check("step_div_rst", 64'(div_rst_o), 64'd1);
        outd_i = 1'b0;
        tick();
        check("step_run", 64'(state_o), 64'(S_RUN));
        check("step_divisor", 64'(divisor_o), 64'd33);
        pulse();
        wait_done();
        check("step_pass", 64'(PASS_COUNT), 64'd1);
        go_idle();

        // synchronous reset in the middle of entry 1
        TABLE_LEN = 3'd2; DIV0 = 32'd4; REP0 = 32'd1; DIV1 = 32'd6; REP1 = 32'd3;
        exp_q.push_back({2'd0, 32'd4});
        exp_q.push_back({2'd1, 32'd6});
        enable_i = 1'b1;
        wait_active();
        pulse();
        wait_active();
        pulse();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("mrst_state", 64'(state_o), 64'(S_IDLE));
        check("mrst_div_rst", 64'(div_rst_o), 64'd1);
        check("mrst_divisor", 64'(divisor_o), 64'd0);
        check("mrst_entry", 64'(ENTRY), 64'd0);
        check("mrst_pass", 64'(PASS_COUNT), 64'd0);
        check("mrst_active", 64'(active_o), 64'd0);
        go_idle();

        // abort together with a terminating pulse, in entry 0 and in the last entry
        TABLE_LEN = 3'd2; DIV0 = 32'd6; REP0 = 32'd1; DIV1 = 32'd7; REP1 = 32'd1;
        exp_q.push_back({2'd0, 32'd6});
        enable_i = 1'b1;
        wait_active();
        outd_i = 1'b1;
        enable_i = 1'b0;
        tick();
        outd_i = 1'b0;
        check("abort0_state", 64'(state_o), 64'(S_IDLE));
        check("abort0_entry", 64'(ENTRY), 64'd0);
        check("abort0_active", 64'(active_o), 64'd0);
        check("abort0_div_rst", 64'(div_rst_o), 64'd1);
        tick();
        exp_q.push_back({2'd0, 32'd6});
        exp_q.push_back({2'd1, 32'd7});
        enable_i = 1'b1;
        wait_active();
        pulse();
        wait_active();
        outd_i = 1'b1;
        enable_i = 1'b0;
        tick();
        outd_i = 1'b0;
        check("abort1_state", 64'(state_o), 64'(S_IDLE));
        check("abort1_entry", 64'(ENTRY), 64'd1);
        check("abort1_done", 64'(done_o), 64'd0);
        check("abort1_pass", 64'(PASS_COUNT), 64'd0);
        go_idle();

        // multi-pass operation: CYCLES=3 repeats only when the pass counter is built
        TABLE_LEN = 3'd1; DIV0 = 32'd9; REP0 = 32'd1; CYCLES = 32'd3;
`ifdef PANDA_DIVSEQ_PASS_COUNT_EN
        exp_passes = 3;
`else
        exp_passes = 1;
`endif
        exp_q.push_back({2'd0, 32'd9});
        enable_i = 1'b1;
        for (int p = 0; p < exp_passes; p++) begin
            wait_active();
            if (p < exp_passes - 1) exp_q.push_back({2'd0, 32'd9});
            pulse();
        end
        wait_done();
        check("cyc_pass", 64'(PASS_COUNT), 64'(exp_passes));
        check("cyc_queue_empty", 64'(exp_q.size()), 64'd0);
        go_idle();

`ifdef PANDA_DIVSEQ_PASS_COUNT_EN
        CYCLES = 32'd0;
        exp_q.push_back({2'd0, 32'd9});
        enable_i = 1'b1;
        for (int p = 0; p < 10; p++) begin
            wait_active();
            exp_q.push_back({2'd0, 32'd9});
            pulse();
        end
        check("inf_pass", 64'(PASS_COUNT), 64'd10);
        check("inf_not_done", 64'(done_o), 64'd0);
        check("inf_active", 64'(active_o), 64'd1);
        go_idle();
`endif

        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
